if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
- REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble encoding.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
- REQ-005 stall  input  1  hazard-unit hold request for PC and IF/ID register.
- REQ-006 redirect_valid  input  1  taken branch/jump resolved downstream; flush and redirect.
- REQ-007 redirect_pc  input  32  target PC for redirect.
- REQ-008 imem_rdata  input  32  instruction word at imem_addr, combinational (same-cycle) memory read.
- REQ-009 imem_addr  output  32  fetch address; equals pcIF.
- REQ-010 pcIF  output  32  current PC register.
- REQ-011 pcID  output  32  PC of instruction held in IF/ID register.
- REQ-012 instrID  output  32  instruction held in IF/ID register.
- REQ-013 validID  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.

Function
- REQ-014 imem_addr and pcIF SHALL be driven directly from the PC register, no combinational path from inputs.
- REQ-015 Normal cycle (rst=1, redirect_valid=0, stall=0): PC <= PC+4; IF/ID <= {pcIF, imem_rdata, valid=1}.
- REQ-016 Stall cycle (redirect_valid=0, stall=1): PC, pcID, instrID, validID SHALL all hold.
- REQ-017 Redirect cycle (redirect_valid=1): PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble {pcID=0, instrID=NOP_INSTR, validID=0}.
- REQ-018 redirect_valid=1 and stall=1 simultaneously: redirect SHALL win (REQ-017 applies).
- REQ-019 redirect_pc[1:0] SHALL be ignored (forced to 00); no error flagged.
- REQ-020 PC increment SHALL be modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000.
- REQ-021 Fetch-to-ID latency SHALL be exactly one cycle: word at imem_addr in cycle N appears on instrID in cycle N+1 unless a stall or redirect occurs in cycle N.
- REQ-022 Back-to-back redirects SHALL each reload PC and each produce a bubble; no fetched instruction between them reaches validID=1.
- REQ-023 Block SHALL contain no further state besides PC, IF/ID register and optional counters.

Reset
- REQ-024 While rst=0 at a clock edge: PC <= RESET_PC, pcID <= 0, instrID <= NOP_INSTR, validID <= 0; overrides stall and redirect.
- REQ-025 First edge with rst=1 SHALL capture instruction at RESET_PC into IF/ID (validID=1) and advance PC to RESET_PC+4 (absent stall/redirect).
- REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation completely.

Configuration
- REQ-027 Macro IF_PERF_CNT_EN SHALL, when defined, add outputs fetch_cnt (32), stall_cnt (32), flush_cnt (32).
- REQ-028 With IF_PERF_CNT_EN: fetch_cnt +1 per REQ-015 cycle, stall_cnt +1 per REQ-016 cycle, flush_cnt +1 per REQ-017 cycle; all reset to 0 under REQ-024; wrap modulo 2^32.
- REQ-029 Without IF_PERF_CNT_EN: ports and counter logic SHALL be absent; all other behaviour identical.

Verification
- REQ-030 Reset release, imem returns 00a28313 at 0, 01228393 at 4, no stall -> cycle 1: pcID=0, instrID=00a28313, validID=1; cycle 2: pcID=4, instrID=01228393; pcIF=8.
- REQ-031 stall=1 for 2 cycles with pcIF=8, pcID=4 -> pcIF stays 8, pcID stays 4, instrID unchanged; after release pcID=8 next cycle.
- REQ-032 redirect_valid=1, redirect_pc=32'h18 at pcIF=4 -> next cycle pcIF=18, instrID=00000013, validID=0, pcID=0; following cycle pcID=18, validID=1.
- REQ-033 redirect_valid=1 and stall=1 together, redirect_pc=32'h1B -> pcIF=18, bubble in IF/ID; RESET_PC=32'hFFFFFFFC run -> pcIF 0xFFFFFFFC then 0x0.
- REQ-034 rst=0 during stall with pcIF=20 -> next cycle pcIF=RESET_PC, validID=0, instrID=00000013; with IF_PERF_CNT_EN, 3 fetches/2 stalls/1 flush -> fetch_cnt=3, stall_cnt=2, flush_cnt=1, all 0 after reset.

Source files
------------

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: hazard/redirect controls, imem port and IF/ID register view
interface if_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pcIF;
  logic [31:0] pcID;
  logic [31:0] instrID;
  logic        validID;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, pcIF, pcID, instrID, validID
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, pcIF, pcID, instrID, validID
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register plus IF/ID pipeline register
// Optional macro IF_PERF_CNT_EN adds fetch/stall/flush performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_STALL = 2'd1,
    OP_FLUSH = 2'd2
  } op_t;

  op_t         op;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic [31:0] redirect_target;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  // Redirect outranks stall: a flushed instruction must never be held.
  always_comb begin
    op = OP_FETCH;
    if (bus.redirect_valid) begin
      op = OP_FLUSH;
    end else if (bus.stall) begin
      op = OP_STALL;
    end
  end

  // Low target bits are discarded rather than flagged; PC stays word aligned.
  assign redirect_target = bus.redirect_pc & ~32'h00000003;
  assign pc_next_seq     = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      pc_id    <= 32'h00000000;
      instr_id <= NOP_INSTR;
      valid_id <= 1'b0;
    end else begin
      case (op)
        OP_FLUSH: begin
          pc       <= redirect_target;
          pc_id    <= 32'h00000000;
          instr_id <= NOP_INSTR;
          valid_id <= 1'b0;
        end
        OP_FETCH: begin
          pc       <= pc_next_seq;
          pc_id    <= pc;
          instr_id <= bus.imem_rdata;
          valid_id <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.pcIF      = pc;
  assign bus.pcID      = pc_id;
  assign bus.instrID   = instr_id;
  assign bus.validID   = valid_id;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= 32'h00000000;
      stall_cnt <= 32'h00000000;
      flush_cnt <= 32'h00000000;
    end else begin
      case (op)
        OP_FETCH: fetch_cnt <= fetch_cnt + 32'd1;
        OP_STALL: stall_cnt <= stall_cnt + 32'd1;
        OP_FLUSH: flush_cnt <= flush_cnt + 32'd1;
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage with a cycle-level reference model
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  if_stage_if bus0 ();
  if_stage_if bus1 ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fc0, sc0, lc0, fc1, sc1, lc1;
`endif

  if_stage #(.RESET_PC(32'h00000000), .NOP_INSTR(32'h00000013)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fc0), .stall_cnt(sc0), .flush_cnt(lc0)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFFFFFC), .NOP_INSTR(32'h00000013)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fc1), .stall_cnt(sc1), .flush_cnt(lc1)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h00a28313;
    if (a == 32'h4) return 32'h01228393;
    return a ^ 32'hA5C30000;
  endfunction

  assign bus0.imem_rdata = mem(bus0.imem_addr);
  assign bus1.imem_rdata = mem(bus1.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must hold after each edge, from the stage rules.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_pcid, m_instr;
  logic        m_valid;
  logic [31:0] m_fetch, m_stall, m_flush;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc = 32'h0; m_pcid = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
      m_fetch = 0; m_stall = 0; m_flush = 0;
      m_known = 1'b1;
    end else if (bus0.redirect_valid) begin
      m_pc = {bus0.redirect_pc[31:2], 2'b00};
      m_pcid = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
      m_flush = m_flush + 1;
    end else if (bus0.stall) begin
      m_stall = m_stall + 1;
    end else begin
      m_pcid = m_pc; m_instr = mem(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_fetch = m_fetch + 1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_pcIF", bus0.pcIF, m_pc);
      chk("model_imem_addr", bus0.imem_addr, m_pc);
      chk("model_pcID", bus0.pcID, m_pcid);
      chk("model_instrID", bus0.instrID, m_instr);
      chk("model_validID", {31'd0, bus0.validID}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
      chk("model_fetch_cnt", fc0, m_fetch);
      chk("model_stall_cnt", sc0, m_stall);
      chk("model_flush_cnt", lc0, m_flush);
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    rst = r;
    bus0.stall = s;
    bus0.redirect_valid = rv;
    bus0.redirect_pc = rp;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus0.stall = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = 32'h0;
    bus1.stall = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0;

    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h44);
    chk("rst_pcIF", bus0.pcIF, 32'h0);
    chk("rst_pcID", bus0.pcID, 32'h0);
    chk("rst_instrID", bus0.instrID, 32'h00000013);
    chk("rst_validID", {31'd0, bus0.validID}, 32'h0);
    chk("rst_hi_pcIF", bus1.pcIF, 32'hFFFFFFFC);

    step(1, 0, 0, 0);
    chk("c1_pcID", bus0.pcID, 32'h0);
    chk("c1_instrID", bus0.instrID, 32'h00a28313);
    chk("c1_validID", {31'd0, bus0.validID}, 32'h1);
    chk("wrap_pcIF", bus1.pcIF, 32'h0);
    chk("wrap_pcID", bus1.pcID, 32'hFFFFFFFC);
    step(1, 0, 0, 0);
    chk("c2_pcID", bus0.pcID, 32'h4);
    chk("c2_instrID", bus0.instrID, 32'h01228393);
    chk("c2_pcIF", bus0.pcIF, 32'h8);

    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("stall_pcIF", bus0.pcIF, 32'h8);
    chk("stall_pcID", bus0.pcID, 32'h4);
    chk("stall_instrID", bus0.instrID, 32'h01228393);
    step(1, 0, 0, 0);
    chk("unstall_pcID", bus0.pcID, 32'h8);

    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pre_redir_pcIF", bus0.pcIF, 32'h4);
    step(1, 0, 1, 32'h18);
    chk("redir_pcIF", bus0.pcIF, 32'h18);
    chk("redir_instrID", bus0.instrID, 32'h00000013);
    chk("redir_validID", {31'd0, bus0.validID}, 32'h0);
    chk("redir_pcID", bus0.pcID, 32'h0);
    step(1, 0, 0, 0);
    chk("post_redir_pcID", bus0.pcID, 32'h18);
    chk("post_redir_validID", {31'd0, bus0.validID}, 32'h1);

    step(1, 1, 1, 32'h1B);
    chk("redir_stall_pcIF", bus0.pcIF, 32'h18);
    chk("redir_stall_validID", {31'd0, bus0.validID}, 32'h0);

    step(1, 0, 1, 32'h40);
    chk("b2b1_validID", {31'd0, bus0.validID}, 32'h0);
    step(1, 0, 1, 32'h83);
    chk("b2b2_pcIF", bus0.pcIF, 32'h80);
    chk("b2b2_validID", {31'd0, bus0.validID}, 32'h0);
    step(1, 0, 0, 0);
    chk("b2b_next_pcID", bus0.pcID, 32'h80);

    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 32'h1C);
`ifdef IF_PERF_CNT_EN
    chk("cnt_fetch", fc0, 32'd3);
    chk("cnt_stall", sc0, 32'd2);
    chk("cnt_flush", lc0, 32'd1);
`endif
    step(1, 0, 0, 0);
    chk("pre_rst_pcIF", bus0.pcIF, 32'h20);
    step(0, 1, 0, 0);
    chk("rst_stall_pcIF", bus0.pcIF, 32'h0);
    chk("rst_stall_validID", {31'd0, bus0.validID}, 32'h0);
    chk("rst_stall_instrID", bus0.instrID, 32'h00000013);
`ifdef IF_PERF_CNT_EN
    chk("cnt_fetch_rst", fc0, 32'd0);
    chk("cnt_stall_rst", sc0, 32'd0);
    chk("cnt_flush_rst", lc0, 32'd0);
`endif
    step(0, 0, 1, 32'h50);
    chk("rst_redir_pcIF", bus0.pcIF, 32'h0);

    for (int i = 0; i < 24; i++) begin
      case (i % 6)
        0, 1:    step(1, 0, 0, 0);
        2:       step(1, 1, 0, 0);
        3:       step(1, 0, 1, 32'h100 + 32'(i * 4) + 32'(i % 4));
        4:       step(1, 1, 1, 32'h200 + 32'(i));
        default: step(1, 0, 0, 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
